keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner: drives one-hot row strobes, samples active-high column returns, debounces across full scan frames, and queues key events in a small FIFO with a valid/ready output. It replaces the fixed 4x3 `keypad` block as the front end for user key entry. It adds arbitrary row/column counts, multi-frame debounce, back-pressure, overflow reporting and optional release events.

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/keypad_evt_fifo.sv | 66 ++++++
 rtl/keypad_scanner.sv | 209 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the keypad scanner.
//   kp_state_e : debounce FSM states (IDLE, PRESS_DB, HELD, REL_DB)
//   kp_evt_t   : queued key event {code, rel}; code is held in a fixed
//                KP_CODE_MAX_W field, so ROWS*COLS must not exceed 256
//   kp_width() : bits needed to hold the values 0..n-1 (at least 1)
package keypad_pkg;

  localparam int KP_CODE_MAX_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } kp_state_e;

  typedef struct packed {
    logic [KP_CODE_MAX_W-1:0] code;
    logic                     rel;
  } kp_evt_t;

  function automatic int kp_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// keypad_evt_fifo: synchronous FIFO for key events with a sticky drop flag.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (empties the queue)
//   push, din : write request and data; dropped when full unless a pop
//               happens in the same cycle
//   valid     : head entry present
//   ready     : consumer accepts the head
//   dout      : head entry
//   overflow  : sticky, set when a push was dropped; cleared only by rst
// Handshake: an entry leaves the head on a rising clk edge where valid and
// ready are both high; dout is stable while valid is high and ready is low.
// A pop while empty does nothing.
module keypad_evt_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] dout,
  output logic         overflow
);

  localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          wr_en;

  assign valid = (count != '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign pop   = valid && ready;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign wr_en = push && (!full || pop);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push && !wr_en) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix keypad front end. Strobes one row at a time,
// samples the active-high column returns at the end of each row dwell,
// debounces the assembled frame over several full scans and queues
// press (and optionally release) events.
// Build option: define KEYPAD_RELEASE_EVT_EN to queue release events;
// otherwise releases only return the FSM to IDLE and key_release is 0.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   key_col     : column returns, bit COLS-1 is column 0
//   key_row     : one-hot row strobe, bit ROWS-1 is row 0
//   key_valid   : event queue head present
//   key_ready   : consumer takes the head when high with key_valid
//   key_code    : head event scan index, row*COLS+col
//   key_release : head event is a release
//   key_pressed : a debounced key is currently held
//   overflow    : sticky, an event was dropped because the queue was full
//   dbg_state   : debounce FSM state
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 3,
  parameter int SCAN_DIV   = 16,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int CODE_W    = kp_width(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COLS-1:0]   key_col,
  output logic [ROWS-1:0]   key_row,
  output logic              key_valid,
  input  logic              key_ready,
  output logic [CODE_W-1:0] key_code,
  output logic              key_release,
  output logic              key_pressed,
  output logic              overflow,
  output kp_state_e         dbg_state
);

`ifdef KEYPAD_RELEASE_EVT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  localparam int FW = ROWS * COLS;
  localparam int RW = kp_width(ROWS);
  localparam int DW = kp_width(SCAN_DIV);
  localparam int CW = kp_width(DEBOUNCE + 1);

  // ---------------- row scan ----------------
  logic [RW-1:0]   row_q;
  logic [DW-1:0]   dwell_q;
  logic [FW-1:0]   frame_q;
  logic [FW-1:0]   frame_now;
  logic [COLS-1:0] col_rev;
  logic            sample;
  logic            fdone;

  assign sample  = (dwell_q == DW'(SCAN_DIV - 1));
  assign fdone   = sample && (row_q == RW'(ROWS - 1));
  assign key_row = {1'b1, {(ROWS-1){1'b0}}} >> row_q;

  // frame_now includes the row being sampled this cycle, so the last row
  // is part of the frame evaluated on fdone.
  always_comb begin
    col_rev = '0;
    for (int c = 0; c < COLS; c++) col_rev[c] = key_col[COLS-1-c];
    frame_now = frame_q;
    if (sample) frame_now = frame_q | (FW'(col_rev) << (int'(row_q) * COLS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q   <= '0;
      dwell_q <= '0;
      frame_q <= '0;
    end else if (sample) begin
      dwell_q <= '0;
      row_q   <= (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
      frame_q <= fdone ? '0 : frame_now;
    end else begin
      dwell_q <= dwell_q + 1'b1;
    end
  end

  // ---------------- debounce FSM ----------------
  kp_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CODE_W-1:0] cur_q, cur_d;
  logic [CODE_W-1:0] cand;
  logic              frame_any;
  logic              cur_hit;
  logic              push_q, push_d;
  logic              rel_q, rel_d;

  // Lowest set index wins; other simultaneous keys are ignored.
  always_comb begin
    cand = '0;
    for (int i = FW - 1; i >= 0; i--) if (frame_now[i]) cand = CODE_W'(i);
    frame_any = |frame_now;
    cur_hit   = frame_now[cur_q];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    push_d  = 1'b0;
    rel_d   = 1'b0;
    if (fdone) begin
      case (state_q)
        IDLE: if (frame_any) begin
          cur_d = cand;
          cnt_d = CW'(1);
          if (DEBOUNCE == 1) begin
            push_d  = 1'b1;
            state_d = HELD;
          end else begin
            state_d = PRESS_DB;
          end
        end
        PRESS_DB: if (frame_any && cand == cur_q) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(DEBOUNCE)) begin
            push_d  = 1'b1;
            state_d = HELD;
          end
        end else begin
          state_d = IDLE;
        end
        HELD: if (!cur_hit) begin
          cnt_d = CW'(1);
          if (DEBOUNCE == 1) begin
            push_d  = REL_EN;
            rel_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = REL_DB;
          end
        end
        REL_DB: if (!cur_hit) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(DEBOUNCE)) begin
            push_d  = REL_EN;
            rel_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          state_d = HELD;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The push is registered, so it reaches the queue the cycle after fdone.
  // cur_q cannot change before the next fdone, so it supplies the code.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      push_q  <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      push_q  <= push_d;
      rel_q   <= rel_d;
    end
  end

  assign key_pressed = (state_q == HELD) || (state_q == REL_DB);
  assign dbg_state   = state_q;

  // ---------------- event queue ----------------
  kp_evt_t evt_in;
  kp_evt_t head;
  logic    unused_head;

  assign evt_in.code = KP_CODE_MAX_W'(cur_q);
  assign evt_in.rel  = rel_q;

  keypad_evt_fifo #(
    .W     ($bits(kp_evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_q),
    .din      (evt_in),
    .valid    (key_valid),
    .ready    (key_ready),
    .dout     (head),
    .overflow (overflow)
  );

  assign key_code    = head.code[CODE_W-1:0];
  assign unused_head = ^head;
`ifdef KEYPAD_RELEASE_EVT_EN
  assign key_release = head.rel;
`else
  assign key_release = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with SCAN_DIV=4
// (16-cycle frame) and DEBOUNCE=2. A behavioural keypad turns the set of
// held keys into column returns for whichever row is strobed. Cycle n is
// counted from reset release; frame F covers cycles 16F..16F+15 and a
// press pushed at the end of frame F shows key_valid in cycle 16F+17.
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic       clk;
  logic       rst;
  logic [2:0] key_col;
  logic [3:0] key_row;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] key_code;
  logic       key_release;
  logic       key_pressed;
  logic       overflow;
  kp_state_e  dbg_state;

  logic [11:0] keys;
  int          cyc;
  int          checks;
  int          errors;
  logic [4:0]  exp_q[$];   // {release, code}
  int          model_cnt;
  int          seq_codes[5];

  keypad_scanner #(
    .ROWS(4), .COLS(3), .SCAN_DIV(4), .DEBOUNCE(2), .FIFO_DEPTH(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_col     (key_col),
    .key_row     (key_row),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_code    (key_code),
    .key_release (key_release),
    .key_pressed (key_pressed),
    .overflow    (overflow),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // ---------------- keypad model ----------------
  always_comb begin
    key_col = '0;
    for (int r = 0; r < 4; r++)
      if (key_row[3-r])
        for (int c = 0; c < 3; c++) key_col[2-c] = key_col[2-c] | keys[r*3+c];
  end

  // ---------------- driver tasks ----------------
  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected queue with a depth-4 occupancy model while the consumer stalls.
  task automatic model_push(input logic [4:0] e);
    if (model_cnt < 4) begin
      exp_q.push_back(e);
      model_cnt++;
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && key_valid && key_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_event: got %0h expected none", {key_release, key_code});
      end
      if (exp_q.size() != 0) begin
        assert ({key_release, key_code} === exp_q[0]) else begin
          errors++;
          $error("FAIL event: got %0h expected %0h", {key_release, key_code}, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    checks    = 0;
    errors    = 0;
    model_cnt = 0;
    seq_codes = '{5, 0, 11, 3, 6};
    rst       = 1'b1;
    keys      = '0;
    key_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_row",      key_row, 4'b1000);
    check("rst_valid",    key_valid, 0);
    check("rst_code",     key_code, 0);
    check("rst_release",  key_release, 0);
    check("rst_pressed",  key_pressed, 0);
    check("rst_overflow", overflow, 0);
    check("rst_state",    dbg_state, IDLE);
    rst = 1'b0;

    // Code 4 (row 1, col 1) held for frames 0..2
    keys[4] = 1'b1;
    exp_q.push_back({1'b0, 4'd4});
    at(3);  check("row0_dwell", key_row, 4'b1000);
    at(4);  check("row1",       key_row, 4'b0100);
    at(32); check("press_not_yet", key_valid, 0);
    at(33);
    check("press_valid",   key_valid, 1);
    check("press_code",    key_code, 4);
    check("press_release", key_release, 0);
    check("press_pressed", key_pressed, 1);
    at(34); check("press_popped", key_valid, 0);
    at(47);
    check("held_pressed", key_pressed, 1);
    check("held_state",   dbg_state, HELD);

    // Release of code 4 over frames 3 and 4
    at(48);
    keys = '0;
`ifdef KEYPAD_RELEASE_EVT_EN
    exp_q.push_back({1'b1, 4'd4});
`endif
    at(65); check("rel_db_state",   dbg_state, REL_DB);
    at(79); check("rel_db_pressed", key_pressed, 1);
    at(80); keys[9] = 1'b1;        // one-frame press of code 9 in frame 5
    at(81);
    check("rel_pressed", key_pressed, 0);
`ifdef KEYPAD_RELEASE_EVT_EN
    check("rel_valid",   key_valid, 1);
    check("rel_code",    key_code, 4);
    check("rel_release", key_release, 1);
`else
    check("rel_no_event", key_valid, 0);
`endif
    at(96);  keys = '0;
    at(100); check("short_press_db", dbg_state, PRESS_DB);
    at(113);
    check("short_idle",     dbg_state, IDLE);
    check("short_no_event", key_valid, 0);
    check("short_no_left",  exp_q.size(), 0);

    // Five presses with the consumer stalled: 4 queued, rest dropped
    at(127);
    check("pre_overflow", overflow, 0);
    key_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      model_push({1'b0, 4'(seq_codes[i])});
`ifdef KEYPAD_RELEASE_EVT_EN
      model_push({1'b1, 4'(seq_codes[i])});
`endif
    end
    for (int i = 0; i < 5; i++) begin
      at(16 * (8 + 4 * i));
      keys = '0;
      keys[seq_codes[i]] = 1'b1;
      at(16 * (10 + 4 * i));
      keys = '0;
    end
    at(420);
    check("stall_valid",    key_valid, 1);
    check("stall_head",     {key_release, key_code}, exp_q[0]);
    check("stall_overflow", overflow, 1);
    at(456);
    check("stall_head_kept", {key_release, key_code}, exp_q[0]);
    key_ready = 1'b1;
    at(470);
    check("drain_valid",    key_valid, 0);
    check("drain_all",      exp_q.size(), 0);
    check("overflow_stick", overflow, 1);

    // Codes 7 and 2 together: only the lower index is reported
    at(480);
    keys[7] = 1'b1;
    keys[2] = 1'b1;
    exp_q.push_back({1'b0, 4'd2});
    at(513);
    check("multi_valid", key_valid, 1);
    check("multi_code",  key_code, 2);
    at(543);
    check("multi_pressed",  key_pressed, 1);
    check("multi_one_only", exp_q.size(), 0);
    at(544);
    keys = '0;
`ifdef KEYPAD_RELEASE_EVT_EN
    exp_q.push_back({1'b1, 4'd2});
`endif
    at(590);
    check("multi_idle",    dbg_state, IDLE);
    check("multi_drained", exp_q.size(), 0);

    // Reset during PRESS_DB
    at(592); keys[1] = 1'b1;
    at(612);
    check("mid_db_state", dbg_state, PRESS_DB);
    rst  = 1'b1;
    keys = '0;
    @(posedge clk);
    #1;
    check("rst2_row",      key_row, 4'b1000);
    check("rst2_valid",    key_valid, 0);
    check("rst2_pressed",  key_pressed, 0);
    check("rst2_overflow", overflow, 0);
    check("rst2_state",    dbg_state, IDLE);
    check("rst2_code",     key_code, 0);
    rst = 1'b0;
    at(40);
    check("post_rst_no_event", key_valid, 0);
    check("post_rst_idle",     dbg_state, IDLE);
    check("post_rst_queue",    exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
